// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite request bridge: response codes, FSM states
// and the queued request entry.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances zero-extend on push and the constant upper bits fold away.
    localparam int REQ_ADDR_MAX = 64;
    localparam int REQ_DATA_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axil_state_e;

    typedef struct packed {
        logic                      write;
        logic [REQ_ADDR_MAX-1:0]   addr;
        logic [REQ_DATA_MAX-1:0]   wdata;
        logic [REQ_DATA_MAX/8-1:0] wstrb;
    } req_entry_t;

endpackage

// File: rtl/axil_req_fifo.sv
// Generic synchronous FIFO with registered storage and wrap-bit pointers;
// a pushed entry becomes visible on o_data the cycle after the push.
module axil_req_fifo
    import axil_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = req_entry_t
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A simultaneous pop frees the slot being written, so full does not block it.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/axil_req_bridge.sv
// Queues local read/write requests and issues each as one AXI4-Lite transaction,
// one at a time. Optional counters are built when AXIL_BRIDGE_STATS_EN is defined.
module axil_req_bridge
    import axil_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter int         DATA_WIDTH = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY,
    output axil_state_e             o_dbg_state
`ifdef AXIL_BRIDGE_STATS_EN
    ,
    output logic [15:0]             stat_wr_cnt,
    output logic [15:0]             stat_rd_cnt,
    output logic [15:0]             stat_err_cnt
`endif
);

    axil_state_e             r_state, w_state_nxt;
    logic                    r_awvalid, w_awvalid_nxt;
    logic                    r_wvalid, w_wvalid_nxt;
    logic                    r_bready, w_bready_nxt;
    logic                    r_arvalid, w_arvalid_nxt;
    logic                    r_rready, w_rready_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic                    r_rsp_write, w_rsp_write_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]              r_rsp_resp, w_rsp_resp_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;

    req_entry_t w_push_entry;
    req_entry_t w_head;
    req_entry_t w_unused_head;
    logic       w_push;
    logic       w_pop;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_aw_done;
    logic       w_w_done;

    assign req_ready = !reset && !w_fifo_full;
    assign w_push    = req_valid && req_ready;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.write = req_write;
        w_push_entry.addr  = REQ_ADDR_MAX'(req_addr);
        w_push_entry.wdata = REQ_DATA_MAX'(req_wdata);
        w_push_entry.wstrb = (REQ_DATA_MAX/8)'(req_wstrb);
    end

    axil_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_entry_t)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .o_full  (w_fifo_full),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty)
    );

    assign w_unused_head = w_head;

    // Each write channel is done once its handshake has happened, now or earlier.
    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wvalid  || WREADY;

    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head.write) begin
                        w_state_nxt   = ST_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (AWREADY) w_awvalid_nxt = 1'b0;
                if (WREADY)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    w_state_nxt     = ST_RSP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = BRESP;
                end
            end
            ST_RD_ADDR: begin
                if (ARREADY) begin
                    w_state_nxt   = ST_RD_DATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    w_state_nxt     = ST_RSP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b0;
                    w_rsp_rdata_nxt = RDATA;
                    w_rsp_resp_nxt  = RRESP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            if (w_pop) begin
                r_addr <= w_head.addr[ADDR_WIDTH-1:0];
                if (w_head.write) begin
                    r_wdata <= w_head.wdata[DATA_WIDTH-1:0];
                    r_wstrb <= w_head.wstrb[DATA_WIDTH/8-1:0];
                end
            end
        end
    end

    assign AWADDR      = r_addr;
    assign AWPROT      = PROT;
    assign AWVALID     = r_awvalid;
    assign WDATA       = r_wdata;
    assign WSTRB       = r_wstrb;
    assign WVALID      = r_wvalid;
    assign BREADY      = r_bready;
    assign ARADDR      = r_addr;
    assign ARPROT      = PROT;
    assign ARVALID     = r_arvalid;
    assign RREADY      = r_rready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign o_dbg_state = r_state;

`ifdef AXIL_BRIDGE_STATS_EN
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_err;
    logic        w_rsp_fire;

    assign w_rsp_fire = r_rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_err <= '0;
        end else if (w_rsp_fire) begin
            if (r_rsp_write && r_stat_wr != 16'hFFFF)  r_stat_wr <= r_stat_wr + 16'd1;
            if (!r_rsp_write && r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 16'd1;
            if (r_rsp_resp != RESP_OKAY && r_stat_err != 16'hFFFF)
                r_stat_err <= r_stat_err + 16'd1;
        end
    end

    assign stat_wr_cnt  = r_stat_wr;
    assign stat_rd_cnt  = r_stat_rd;
    assign stat_err_cnt = r_stat_err;
`endif

endmodule
